pc_branch_unit: RTL
===================

// Module: pc_branch_unit
// PURPOSE
//  Program-counter register and control-transfer resolver for the RV32I core.
//  Consumes the ALU's ALU_Result and zero flag to resolve BEQ/BNE, JAL and JALR.
//  Produces the next fetch PC, a one-cycle fetch-redirect pulse and a retired-instruction count.
//  Enters a sticky trap state on a misaligned taken target.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-low reset
//  instr_valid  in   1   instruction at PC_out is valid this cycle
//  stall        in   1   hold all state this cycle
//  Branch       in   1   conditional branch instruction
//  funct3       in   3   branch condition (000 BEQ, 001 BNE)
//  Jump         in   1   JAL
//  JumpReg      in   1   JALR
//  zero         in   1   ALU zero flag (A==B under SUB)
//  ALU_Result   in   32  ALU sum; JALR target (rs1+imm)
//  ImmExt       in   32  sign-extended immediate (branch/JAL offset)
//  PC_out       out  32  current PC (registered)
//  PC_plus4     out  32  PC_out+4, combinational (link value)
//  Redirect     out  1   registered pulse: PC was loaded from a taken transfer
//  Misaligned   out  1   sticky trap flag
//  Trap_PC      out  32  PC of the faulting instruction
//  instret      out  32  retired-instruction counter
// BEHAVIOUR
//  Reset (reset==0 at edge): PC_out=RESET_PC, Redirect=0, Misaligned=0, Trap_PC=0, instret=0, state=RUN.
//   Reset overrides every other input, including in TRAP.
//  States:
//   RUN: normal operation.
//   TRAP: entered on a misaligned taken target; left only by reset.
//  accept = instr_valid & ~stall & (state==RUN).
//   When accept==0: PC_out, instret and Trap_PC hold; Redirect=0 next cycle.
//  Target selection (priority JumpReg > Jump > Branch):
//   JumpReg: tgt = ALU_Result & ~32'h1; taken=1.
//   Jump:    tgt = PC_out + ImmExt; taken=1.
//   Branch:  tgt = PC_out + ImmExt; taken = (funct3==000 & zero) | (funct3==001 & ~zero).
//   Branch with any other funct3: not taken.
//   None asserted: taken=0.
//  Misalignment: taken & (tgt[1:0]!=0).
//   On accept: state->TRAP, Misaligned=1, Trap_PC=PC_out; PC_out holds; instret holds; Redirect=0.
//   An untaken branch is never checked.
//  On accept and no misalignment:
//   PC_out <= taken ? tgt : PC_out+4.
//   instret <= instret+1.
//   Redirect <= taken, high for exactly the cycle following the update.
//  Arithmetic: all sums are 32-bit, modulo 2^32.
//   PC_out+4 wraps 0xFFFF_FFFC->0; instret wraps 0xFFFF_FFFF->0.
//  Latency: one cycle from accept to new PC_out; PC_plus4 follows PC_out combinationally.
// TESTING
//  1. RESET_PC=0x100, hold reset=0 2 cycles -> PC_out=0x100, PC_plus4=0x104, Redirect=0, Misaligned=0, instret=0.
//  2. 3 valid cycles, no control -> PC_out 0x104,0x108,0x10C; Redirect=0; instret=3.
//     With stall=1 for 2 cycles mid-run -> no change.
//  3. PC=0x10C, Branch=1, funct3=000, zero=1, ImmExt=0xFFFF_FFF4 -> PC=0x100, Redirect=1 one cycle.
//     Same with funct3=001 -> PC=0x110, Redirect=0.
//  4. JumpReg=1 and Jump=1 together, ALU_Result=0x2001 -> PC=0x2000 (JALR wins, bit0 cleared).
//  5. PC=0x2000, Jump=1, ImmExt=0x6 -> Misaligned=1, Trap_PC=0x2000, PC holds, instret holds.
//     Further valid instructions are ignored; reset=0 clears to RESET_PC.
//  6. RESET_PC=0xFFFF_FFFC, one valid cycle -> PC_out=0x0, PC_plus4=0x4.
//     instret preset near 0xFFFF_FFFF (force) wraps to 0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter and control-transfer resolver: picks the next fetch PC from
// JALR/JAL/BEQ/BNE, counts retired instructions and traps on misaligned targets.
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        Branch,
    input  logic [2:0]  funct3,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        zero,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] ImmExt,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    output logic        Redirect,
    output logic        Misaligned,
    output logic [31:0] Trap_PC,
    output logic [31:0] instret,
    output logic        dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] instret_q, instret_d;

    logic        accept;
    logic        taken;
    logic        misalign;
    logic [31:0] tgt;
    logic [31:0] rel_tgt;

    // Handshake: the instruction at PC_out is consumed on a rising edge only when
    // instr_valid is high and stall is low (stall acts as not-ready); a trapped
    // unit never consumes.
    always_comb begin
        accept  = instr_valid & ~stall & (state_q == ST_RUN);
        rel_tgt = pc_q + ImmExt;
        tgt     = rel_tgt;
        taken   = 1'b0;
        if (JumpReg) begin
            tgt   = ALU_Result & ~32'h1;
            taken = 1'b1;
        end else if (Jump) begin
            taken = 1'b1;
        end else if (Branch) begin
            taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
        end
        misalign = taken & (tgt[1:0] != 2'b00);

        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        misaligned_d = misaligned_q;
        trap_pc_d    = trap_pc_q;
        instret_d    = instret_q;
        if (accept) begin
            if (misalign) begin
                state_d      = ST_TRAP;
                misaligned_d = 1'b1;
                trap_pc_d    = pc_q;
            end else begin
                pc_d       = taken ? tgt : pc_q + 32'd4;
                instret_d  = instret_q + 32'd1;
                redirect_d = taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            trap_pc_q    <= 32'h0;
            instret_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
            trap_pc_q    <= trap_pc_d;
            instret_q    <= instret_d;
        end
    end

    assign PC_out     = pc_q;
    assign PC_plus4   = pc_q + 32'd4;
    assign Redirect   = redirect_q;
    assign Misaligned = misaligned_q;
    assign Trap_PC    = trap_pc_q;
    assign instret    = instret_q;
    assign dbg_state  = state_q;

endmodule
